// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dcache_pkg
// Description : Shared widths, geometry and FSM state type for the
//               direct-mapped write-back data cache.
// Revision    : 1.0 - initial release
// ============================================================================
package dcache_pkg;

    localparam int ADDR_WIDTH     = 32;
    localparam int WORD_WIDTH     = 32;
    localparam int LINE_WIDTH     = 256;
    localparam int NUM_LINES      = 16;
    localparam int INDEX_WIDTH    = 4;
    localparam int OFFSET_WIDTH   = 5;
    localparam int WORD_SEL_WIDTH = 3;
    localparam int TAG_WIDTH      = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;

    // Bit position of the word-select field inside a byte address.
    localparam int WORD_SEL_LSB   = 2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MISS      = 2'd1,
        ST_WRITEBACK = 2'd2,
        ST_ALLOCATE  = 2'd3
    } state_t;

    // Extract one 32-bit word from a cache line.
    function automatic logic [WORD_WIDTH-1:0] line_word(
        input logic [LINE_WIDTH-1:0]     line,
        input logic [WORD_SEL_WIDTH-1:0] sel
    );
        return line[sel*WORD_WIDTH +: WORD_WIDTH];
    endfunction

    // Replace one 32-bit word of a cache line.
    function automatic logic [LINE_WIDTH-1:0] line_merge(
        input logic [LINE_WIDTH-1:0]     line,
        input logic [WORD_SEL_WIDTH-1:0] sel,
        input logic [WORD_WIDTH-1:0]     word
    );
        logic [LINE_WIDTH-1:0] merged;
        merged = line;
        merged[sel*WORD_WIDTH +: WORD_WIDTH] = word;
        return merged;
    endfunction

endpackage : dcache_pkg
`default_nettype wire

// File: rtl/dcache_sram.sv
`default_nettype none
// ============================================================================
// Module      : dcache_sram
// Description : Tag, valid, dirty and data storage for the data cache.
//               One asynchronous read port, one synchronous write port.
//               Only valid/dirty are reset; tag and data keep contents.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_sram
    import dcache_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [INDEX_WIDTH-1:0] rd_index,
    output logic [TAG_WIDTH-1:0]   rd_tag,
    output logic                   rd_valid,
    output logic                   rd_dirty,
    output logic [LINE_WIDTH-1:0]  rd_line,
    input  logic                   wr_en,
    input  logic [INDEX_WIDTH-1:0] wr_index,
    input  logic [TAG_WIDTH-1:0]   wr_tag,
    input  logic                   wr_valid,
    input  logic                   wr_dirty,
    input  logic [LINE_WIDTH-1:0]  wr_line
);

    logic [TAG_WIDTH-1:0]  tag_mem  [NUM_LINES];
    logic [LINE_WIDTH-1:0] data_mem [NUM_LINES];
    logic [NUM_LINES-1:0]  valid_bits;
    logic [NUM_LINES-1:0]  dirty_bits;

    assign rd_tag   = tag_mem[rd_index];
    assign rd_line  = data_mem[rd_index];
    assign rd_valid = valid_bits[rd_index];
    assign rd_dirty = dirty_bits[rd_index];

    // Status bits: cleared by reset so every line starts invalid and clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_bits <= '0;
            dirty_bits <= '0;
        end else if (wr_en) begin
            valid_bits[wr_index] <= wr_valid;
            dirty_bits[wr_index] <= wr_dirty;
        end
    end

    // Tag and data arrays: plain storage, never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_line;
        end
    end

endmodule : dcache_sram
`default_nettype wire

// File: rtl/dcache_controller.sv
`default_nettype none
// ============================================================================
// Module      : dcache_controller
// Description : Direct-mapped, write-back, write-allocate data cache
//               controller (16 lines x 32 bytes). Hits complete in IDLE
//               with no stall; misses walk MISS -> [WRITEBACK] -> ALLOCATE
//               against a backing memory with unbounded latency.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_controller
    import dcache_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cpu_req_i,
    input  logic                  cpu_we_i,
    input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
    input  logic [WORD_WIDTH-1:0] cpu_data_i,
    output logic [WORD_WIDTH-1:0] cpu_data_o,
    output logic                  cpu_stall_o,
    output logic                  mem_enable_o,
    output logic                  mem_write_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [LINE_WIDTH-1:0] mem_data_o,
    input  logic [LINE_WIDTH-1:0] mem_data_i,
    input  logic                  mem_ack_i
);

    state_t state;
    state_t next_state;

    // Address fields of the live CPU request.
    logic [TAG_WIDTH-1:0]      cpu_tag;
    logic [INDEX_WIDTH-1:0]    cpu_index;
    logic [WORD_SEL_WIDTH-1:0] cpu_word;
    logic [1:0]                unused_byte_offset;

    assign cpu_tag            = cpu_addr_i[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign cpu_index          = cpu_addr_i[OFFSET_WIDTH +: INDEX_WIDTH];
    assign cpu_word           = cpu_addr_i[WORD_SEL_LSB +: WORD_SEL_WIDTH];
    assign unused_byte_offset = cpu_addr_i[1:0];

    // Missing request captured in IDLE; the CPU bus is ignored afterwards.
    logic [TAG_WIDTH-1:0]   req_tag;
    logic [INDEX_WIDTH-1:0] req_index;

    // Storage interface.
    logic [INDEX_WIDTH-1:0] rd_index;
    logic [TAG_WIDTH-1:0]   rd_tag;
    logic                   rd_valid;
    logic                   rd_dirty;
    logic [LINE_WIDTH-1:0]  rd_line;
    logic                   wr_en;
    logic [INDEX_WIDTH-1:0] wr_index;
    logic [TAG_WIDTH-1:0]   wr_tag;
    logic                   wr_valid;
    logic                   wr_dirty;
    logic [LINE_WIDTH-1:0]  wr_line;

    logic hit;

    // In IDLE the live request addresses the arrays; elsewhere the captured one.
    assign rd_index = (state == ST_IDLE) ? cpu_index : req_index;

    assign hit = (state == ST_IDLE) && cpu_req_i && rd_valid && (rd_tag == cpu_tag);

    dcache_sram u_sram (
        .clk      (clk_i),
        .rst_n    (rst_i),
        .rd_index (rd_index),
        .rd_tag   (rd_tag),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .rd_line  (rd_line),
        .wr_en    (wr_en),
        .wr_index (wr_index),
        .wr_tag   (wr_tag),
        .wr_valid (wr_valid),
        .wr_dirty (wr_dirty),
        .wr_line  (wr_line)
    );

    // State register; reset abandons any memory transfer in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Capture the missing request's tag and index when leaving IDLE.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            req_tag   <= '0;
            req_index <= '0;
        end else if (state == ST_IDLE && cpu_req_i && !hit) begin
            req_tag   <= cpu_tag;
            req_index <= cpu_index;
        end
    end

    // Next-state, Moore memory outputs, CPU outputs and array write port.
    always_comb begin
        next_state   = state;
        cpu_data_o   = '0;
        cpu_stall_o  = 1'b1;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        wr_en        = 1'b0;
        wr_index     = rd_index;
        wr_tag       = rd_tag;
        wr_valid     = 1'b1;
        wr_dirty     = 1'b0;
        wr_line      = rd_line;

        unique case (state)
            ST_IDLE: begin
                cpu_stall_o = cpu_req_i && !hit;
                if (hit) begin
                    cpu_data_o = line_word(rd_line, cpu_word);
                    if (cpu_we_i) begin
                        wr_en    = 1'b1;
                        wr_dirty = 1'b1;
                        wr_line  = line_merge(rd_line, cpu_word, cpu_data_i);
                    end
                end else if (cpu_req_i) begin
                    next_state = ST_MISS;
                end
            end
            ST_MISS: begin
                next_state = (rd_valid && rd_dirty) ? ST_WRITEBACK : ST_ALLOCATE;
            end
            ST_WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {rd_tag, req_index, {OFFSET_WIDTH{1'b0}}};
                mem_data_o   = rd_line;
                if (mem_ack_i) begin
                    next_state = ST_ALLOCATE;
                end
            end
            ST_ALLOCATE: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {req_tag, req_index, {OFFSET_WIDTH{1'b0}}};
                if (mem_ack_i) begin
                    wr_en      = 1'b1;
                    wr_tag     = req_tag;
                    wr_line    = mem_data_i;
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

endmodule : dcache_controller
`default_nettype wire

// File: tb/tb_dcache_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_controller
// Description : Directed self-checking bench for dcache_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_controller;

    logic         clk_i;
    logic         rst_i;
    logic         cpu_req_i;
    logic         cpu_we_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    int tests;
    int fails;

    dcache_controller dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cpu_req_i    (cpu_req_i),
        .cpu_we_i     (cpu_we_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_data_i   (cpu_data_i),
        .cpu_data_o   (cpu_data_o),
        .cpu_stall_o  (cpu_stall_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Refill line whose word i is base + i.
    function automatic logic [255:0] make_line(input logic [31:0] base);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) begin
            l[i*32 +: 32] = base + i;
        end
        return l;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic next_cycle();
        @(negedge clk_i);
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        rst_i      = 1'b0;
        cpu_req_i  = 1'b0;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h0;
        cpu_data_i = 32'h0;
        mem_data_i = '0;
        mem_ack_i  = 1'b0;

        // ---- reset state ----
        next_cycle();
        #1;
        check("rst_mem_enable", mem_enable_o, 1'b0);
        check("rst_mem_write",  mem_write_o,  1'b0);
        check("rst_mem_addr",   mem_addr_o,   32'h0);
        check("rst_mem_data",   mem_data_o,   256'h0);
        check("rst_cpu_data",   cpu_data_o,   32'h0);
        check("rst_stall",      cpu_stall_o,  1'b0);
        next_cycle();
        rst_i = 1'b1;

        // ---- cold miss: load 0x104 ----
        next_cycle();
        cpu_req_i  = 1'b1;
        cpu_addr_i = 32'h0000_0104;
        #1;
        check("cold_stall_idle", cpu_stall_o, 1'b1);
        check("cold_data_idle",  cpu_data_o,  32'h0);
        next_cycle();
        #1;
        check("cold_miss_enable", mem_enable_o, 1'b0);
        check("cold_miss_stall",  cpu_stall_o,  1'b1);
        next_cycle();
        #1;
        check("cold_alloc_enable", mem_enable_o, 1'b1);
        check("cold_alloc_write",  mem_write_o,  1'b0);
        check("cold_alloc_addr",   mem_addr_o,   32'h0000_0100);
        mem_data_i = make_line(32'h1000_0000);
        mem_ack_i  = 1'b1;
        next_cycle();
        mem_ack_i = 1'b0;
        #1;
        check("cold_hit_stall", cpu_stall_o, 1'b0);
        check("cold_hit_data",  cpu_data_o,  32'h1000_0001);

        // ---- store hit 0xDEADBEEF to 0x104 ----
        cpu_we_i   = 1'b1;
        cpu_data_i = 32'hDEAD_BEEF;
        #1;
        check("store_stall", cpu_stall_o, 1'b0);
        next_cycle();
        cpu_we_i = 1'b0;
        #1;
        check("store_readback",       cpu_data_o,  32'hDEAD_BEEF);
        check("store_readback_stall", cpu_stall_o, 1'b0);

        // ---- dirty conflict: load 0x304 ----
        cpu_addr_i = 32'h0000_0304;
        #1;
        check("dirty_stall", cpu_stall_o, 1'b1);
        next_cycle();
        #1;
        check("dirty_miss_enable", mem_enable_o, 1'b0);
        next_cycle();
        #1;
        check("wb_enable", mem_enable_o, 1'b1);
        check("wb_write",  mem_write_o,  1'b1);
        check("wb_addr",   mem_addr_o,   32'h0000_0100);
        check("wb_word1",  mem_data_o[63:32], 32'hDEAD_BEEF);
        check("wb_word0",  mem_data_o[31:0],  32'h1000_0000);
        mem_ack_i = 1'b1;
        next_cycle();
        mem_ack_i = 1'b0;
        #1;
        check("dirty_alloc_enable", mem_enable_o, 1'b1);
        check("dirty_alloc_write",  mem_write_o,  1'b0);
        check("dirty_alloc_addr",   mem_addr_o,   32'h0000_0300);
        mem_data_i = make_line(32'h2000_0000);
        mem_ack_i  = 1'b1;
        next_cycle();
        mem_ack_i = 1'b0;
        #1;
        check("dirty_hit_data",  cpu_data_o,  32'h2000_0001);
        check("dirty_hit_stall", cpu_stall_o, 1'b0);

        // ---- clean conflict: load 0x504, slow memory ----
        cpu_addr_i = 32'h0000_0504;
        #1;
        check("clean_stall", cpu_stall_o, 1'b1);
        next_cycle();
        next_cycle();
        #1;
        check("clean_alloc_enable", mem_enable_o, 1'b1);
        check("clean_alloc_write",  mem_write_o,  1'b0);
        check("clean_alloc_addr",   mem_addr_o,   32'h0000_0500);
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            #1;
            check("slow_enable", mem_enable_o, 1'b1);
            check("slow_addr",   mem_addr_o,   32'h0000_0500);
            check("slow_stall",  cpu_stall_o,  1'b1);
        end
        mem_data_i = make_line(32'h3000_0000);
        mem_ack_i  = 1'b1;
        next_cycle();
        mem_ack_i = 1'b0;
        #1;
        check("clean_hit_data",  cpu_data_o,  32'h3000_0001);
        check("clean_hit_stall", cpu_stall_o, 1'b0);

        // ---- reset mid-ALLOCATE ----
        cpu_addr_i = 32'h0000_0104;
        next_cycle();
        next_cycle();
        #1;
        check("rst_alloc_pre_enable", mem_enable_o, 1'b1);
        check("rst_alloc_pre_addr",   mem_addr_o,   32'h0000_0100);
        #2;
        rst_i = 1'b0;
        #1;
        check("rst_alloc_enable", mem_enable_o, 1'b0);
        check("rst_alloc_addr",   mem_addr_o,   32'h0);
        next_cycle();
        rst_i     = 1'b1;
        cpu_req_i = 1'b0;
        next_cycle();
        mem_ack_i = 1'b1;
        next_cycle();
        mem_ack_i = 1'b0;
        #1;
        check("late_ack_enable", mem_enable_o, 1'b0);
        cpu_req_i  = 1'b1;
        cpu_addr_i = 32'h0000_0104;
        #1;
        check("post_rst_stall", cpu_stall_o, 1'b1);
        check("post_rst_data",  cpu_data_o,  32'h0);
        next_cycle();
        #1;
        check("post_rst_miss_enable", mem_enable_o, 1'b0);
        next_cycle();
        #1;
        check("post_rst_alloc_write", mem_write_o, 1'b0);
        check("post_rst_alloc_addr",  mem_addr_o,  32'h0000_0100);
        mem_data_i = make_line(32'h4000_0000);
        mem_ack_i  = 1'b1;
        next_cycle();
        mem_ack_i = 1'b0;
        #1;
        check("post_rst_hit_data", cpu_data_o, 32'h4000_0001);
        cpu_req_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_dcache_controller
`default_nettype wire

// File: doc/dcache_controller.md
DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 The block SHALL provide one clock and an asynchronous active-low reset: clk_i (rising edge) and rst_i (active-low, asynchronous assert).
REQ-002 clk_i  input  1  core clock.
REQ-003 rst_i  input  1  asynchronous active-low reset.
REQ-004 cpu_req_i  input  1  MEM-stage access request (MemRead or MemWrite).
REQ-005 cpu_we_i  input  1  1 = store, 0 = load.
REQ-006 cpu_addr_i  input  32  byte address; bits [1:0] are ignored.
REQ-007 cpu_data_i  input  32  store data.
REQ-008 cpu_data_o  output  32  load data; 0 when there is no hit.
REQ-009 cpu_stall_o  output  1  pipeline freeze request.
REQ-010 mem_enable_o / mem_write_o  output  1 each  backing-memory request and write strobe.
REQ-011 mem_addr_o  output  32  line-aligned address, bits [4:0] = 0.
REQ-012 mem_data_o  output  256  victim line.
REQ-013 mem_data_i  input  256  refill line.
REQ-014 mem_ack_i  input  1  single-cycle completion pulse.

Function
REQ-015 The cache SHALL be direct-mapped, write-back and write-allocate, with 16 lines of 32 bytes: tag = addr[31:9], index = addr[8:5], word = addr[4:2].
REQ-016 A hit SHALL be defined as cpu_req_i AND valid[index] AND (tag[index] == addr tag), evaluated combinationally in IDLE only.
REQ-017 On a load hit, cpu_data_o SHALL present the selected word in the same cycle, and cpu_stall_o SHALL be 0.
REQ-018 On a store hit, the block SHALL write the selected word and set dirty[index] at the next rising edge, with cpu_stall_o = 0.
REQ-019 cpu_stall_o SHALL equal cpu_req_i AND NOT hit in IDLE, and SHALL be 1 in every other state.
REQ-020 The FSM SHALL have the states IDLE, MISS, WRITEBACK and ALLOCATE.
- IDLE -> MISS on a miss.
- MISS -> WRITEBACK if valid&dirty[index], else -> ALLOCATE.
- WRITEBACK -> ALLOCATE on mem_ack_i.
- ALLOCATE -> IDLE on mem_ack_i.
REQ-021 In WRITEBACK, the block SHALL drive mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 5'b0} and mem_data_o=victim line.
REQ-022 In ALLOCATE, the block SHALL drive mem_enable_o=1, mem_write_o=0 and mem_addr_o={req tag, index, 5'b0}.
REQ-023 All memory outputs SHALL be Moore outputs and SHALL be held stable until mem_ack_i.
REQ-024 mem_enable_o SHALL be 0 in IDLE and MISS.
REQ-025 On mem_ack_i in ALLOCATE, the block SHALL load mem_data_i, tag, valid=1 and dirty=0 into the line at that edge.
REQ-026 The retried request SHALL hit in the following IDLE cycle; a store then applies per REQ-018.
REQ-027 mem_ack_i SHALL be ignored in IDLE and MISS.
REQ-028 cpu_req_i, cpu_we_i, cpu_addr_i and cpu_data_i SHALL be ignored outside IDLE; the requester holds them stable while stalled.
REQ-029 Memory latency SHALL be unbounded, with no timeout.

Reset
REQ-030 While rst_i=0, the block SHALL force the state to IDLE, clear all valid and dirty bits, and drive mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0 and cpu_data_o=0.
REQ-031 The tag and data arrays SHALL NOT be reset.
REQ-032 A reset asserted mid-WRITEBACK or mid-ALLOCATE SHALL abandon the transfer immediately; a late mem_ack_i SHALL be ignored.

Structure
REQ-033 The shared package dcache_pkg SHALL hold the state enum, the line, tag and index widths, and the number of lines.
REQ-034 One sub-module, dcache_sram, SHALL hold the tag, valid, dirty and data arrays with one read and one write port.
REQ-035 The FSM, hit logic and word merge SHALL live in dcache_controller.

Verification
REQ-036 Cold miss: after reset, load 0x00000104 -> stall=1; MISS then ALLOCATE with mem_addr_o=0x00000100 and write=0; after ack, the next cycle has stall=0 and cpu_data_o = mem line word 1.
REQ-037 Store hit: store 0xDEADBEEF to 0x00000104 -> no stall; a following load of 0x00000104 returns 0xDEADBEEF.
REQ-038 Dirty conflict: load 0x00000304 (index 8) -> WRITEBACK with mem_addr_o=0x00000100 and mem_data_o word 1 = 0xDEADBEEF, then ALLOCATE with mem_addr_o=0x00000300.
REQ-039 Clean conflict: then load 0x00000504 -> MISS goes directly to ALLOCATE (0x00000500), with no WRITEBACK.
REQ-040 Slow memory: ack delayed 10 cycles -> mem_enable_o, mem_addr_o and stall are stable for all 10 cycles.
REQ-041 Reset mid-ALLOCATE: rst_i=0 -> mem_enable_o=0 immediately; after release, a late ack is ignored and load 0x00000104 misses.
